// File: rtl/ema_crossover_signal.sv
// Pairs fast/slow EMA samples, registers their exact difference, and runs a
// hysteresis/hold-off crossover state machine issuing buy/sell signals.
//
// state      | meaning
// -----------+--------------------------------------------------------------
// ST_WARMUP  | consuming the first WARMUP evaluated pairs, no signals issued
// ST_NEUTRAL | flat position, waiting for the difference to leave the band
// ST_LONG    | long position, reversal to short gated by the hold-off count
// ST_SHORT   | short position, reversal to long gated by the hold-off count
module ema_crossover_signal #(
    parameter logic [31:0] HYST    = 32'h0000_0800,
    parameter int unsigned HOLDOFF = 4,
    parameter int unsigned WARMUP  = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fast_valid,
    input  logic [31:0] fast_avg,
    input  logic        slow_valid,
    input  logic [31:0] slow_avg,
    output logic        eval_valid,
    output logic [32:0] diff_out,
    output logic        sig_valid,
    output logic        sig_buy,
    output logic        sig_sell,
    output logic [1:0]  position,
    output logic        pair_err
);

    typedef enum logic [1:0] {
        ST_WARMUP  = 2'd0,
        ST_NEUTRAL = 2'd1,
        ST_LONG    = 2'd2,
        ST_SHORT   = 2'd3
    } state_t;

    localparam logic signed [32:0] HYST_POS = $signed({1'b0, HYST});
    localparam logic signed [32:0] HYST_NEG = -HYST_POS;

    state_t             state_q, state_d;
    logic               have_fast, have_slow;
    logic [31:0]        fast_q, slow_q;
    logic               s1_valid;
    logic signed [32:0] s1_diff;
    logic [31:0]        warm_cnt, warm_cnt_d;
    logic [31:0]        hold_cnt, hold_cnt_d;
    logic               buy_d, sell_d;
    logic               pair_done;
    logic [31:0]        fast_use, slow_use;
    logic               above, below;
    logic               decide_flat;

    // A sample arriving this cycle takes priority over the held copy.
    assign pair_done = (fast_valid | have_fast) & (slow_valid | have_slow);
    assign fast_use  = fast_valid ? fast_avg : fast_q;
    assign slow_use  = slow_valid ? slow_avg : slow_q;
    assign above     = s1_diff > HYST_POS;
    assign below     = s1_diff < HYST_NEG;

    always_ff @(posedge clk) begin
        if (rst) begin
            have_fast <= 1'b0;
            have_slow <= 1'b0;
            fast_q    <= '0;
            slow_q    <= '0;
            s1_valid  <= 1'b0;
            s1_diff   <= '0;
            pair_err  <= 1'b0;
        end else begin
            pair_err <= ~pair_done & ((fast_valid & have_fast) | (slow_valid & have_slow));
            s1_valid <= pair_done;
            if (pair_done) begin
                have_fast <= 1'b0;
                have_slow <= 1'b0;
                s1_diff   <= $signed({fast_use[31], fast_use}) - $signed({slow_use[31], slow_use});
            end else begin
                if (fast_valid) begin
                    fast_q    <= fast_avg;
                    have_fast <= 1'b1;
                end
                if (slow_valid) begin
                    slow_q    <= slow_avg;
                    have_slow <= 1'b1;
                end
            end
        end
    end

    // With no warm-up the reset state already makes flat-position decisions.
    assign decide_flat = (state_q == ST_NEUTRAL) || ((state_q == ST_WARMUP) && (WARMUP == 0));

    always_comb begin
        state_d    = state_q;
        warm_cnt_d = warm_cnt;
        hold_cnt_d = hold_cnt;
        buy_d      = 1'b0;
        sell_d     = 1'b0;
        if (s1_valid) begin
            if (decide_flat) begin
                if (above) begin
                    buy_d   = 1'b1;
                    state_d = ST_LONG;
                end else if (below) begin
                    sell_d  = 1'b1;
                    state_d = ST_SHORT;
                end
            end else begin
                case (state_q)
                    ST_WARMUP: begin
                        warm_cnt_d = warm_cnt + 32'd1;
                        if (warm_cnt_d == WARMUP) state_d = ST_NEUTRAL;
                    end
                    ST_LONG: begin
                        if (below && (hold_cnt == 32'd0)) begin
                            sell_d  = 1'b1;
                            state_d = ST_SHORT;
                        end
                    end
                    ST_SHORT: begin
                        if (above && (hold_cnt == 32'd0)) begin
                            buy_d   = 1'b1;
                            state_d = ST_LONG;
                        end
                    end
                    default: state_d = state_q;
                endcase
            end
            if (buy_d || sell_d) hold_cnt_d = HOLDOFF;
            else if (hold_cnt != 32'd0) hold_cnt_d = hold_cnt - 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_WARMUP;
            warm_cnt   <= '0;
            hold_cnt   <= '0;
            eval_valid <= 1'b0;
            diff_out   <= '0;
            sig_valid  <= 1'b0;
            sig_buy    <= 1'b0;
            sig_sell   <= 1'b0;
            position   <= 2'b00;
        end else begin
            state_q    <= state_d;
            warm_cnt   <= warm_cnt_d;
            hold_cnt   <= hold_cnt_d;
            eval_valid <= s1_valid;
            if (s1_valid) diff_out <= s1_diff;
            sig_valid  <= buy_d | sell_d;
            sig_buy    <= buy_d;
            sig_sell   <= sell_d;
            case (state_d)
                ST_LONG:  position <= 2'b01;
                ST_SHORT: position <= 2'b10;
                default:  position <= 2'b00;
            endcase
        end
    end

endmodule

// File: tb/tb_ema_crossover_signal.sv
// Testbench for ema_crossover_signal: two instances (WARMUP=2 and WARMUP=0,
// both HOLDOFF=2) share stimulus; directed tables plus a random model run.
module tb_ema_crossover_signal;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fast_valid = 1'b0;
    logic [31:0] fast_avg = '0;
    logic        slow_valid = 1'b0;
    logic [31:0] slow_avg = '0;

    logic        ev [2];
    logic [32:0] dv [2];
    logic        sgv [2];
    logic        sb [2];
    logic        ss [2];
    logic [1:0]  po [2];
    logic        pe [2];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ema_crossover_signal #(.HYST(32'h800), .HOLDOFF(2), .WARMUP(2)) dut_a (
        .clk(clk), .rst(rst),
        .fast_valid(fast_valid), .fast_avg(fast_avg),
        .slow_valid(slow_valid), .slow_avg(slow_avg),
        .eval_valid(ev[0]), .diff_out(dv[0]), .sig_valid(sgv[0]),
        .sig_buy(sb[0]), .sig_sell(ss[0]), .position(po[0]), .pair_err(pe[0])
    );

    ema_crossover_signal #(.HYST(32'h800), .HOLDOFF(2), .WARMUP(0)) dut_b (
        .clk(clk), .rst(rst),
        .fast_valid(fast_valid), .fast_avg(fast_avg),
        .slow_valid(slow_valid), .slow_avg(slow_avg),
        .eval_valid(ev[1]), .diff_out(dv[1]), .sig_valid(sgv[1]),
        .sig_buy(sb[1]), .sig_sell(ss[1]), .position(po[1]), .pair_err(pe[1])
    );

    // Reference model: pairing rules plus a pair-count/position rule set.
    bit          m_hf [2], m_hs [2], m_pend [2];
    logic [31:0] m_vf [2], m_vs [2];
    longint      m_pdiff [2];
    int          m_n [2], m_pos [2], m_hold [2];
    bit          e_ev [2], e_sv [2], e_b [2], e_s [2], e_pe [2];
    longint      e_diff [2];

    task automatic model_step(input int d, input bit r, input bit fv, input logic [31:0] fa,
                              input bit sv, input logic [31:0] sa);
        int w;
        bit sig;
        bit above, below, complete;
        w = (d == 0) ? 2 : 0;
        if (r) begin
            m_hf[d] = 0; m_hs[d] = 0; m_pend[d] = 0; m_vf[d] = '0; m_vs[d] = '0;
            m_n[d] = 0; m_pos[d] = 0; m_hold[d] = 0;
            e_ev[d] = 0; e_sv[d] = 0; e_b[d] = 0; e_s[d] = 0; e_pe[d] = 0; e_diff[d] = 0;
            return;
        end
        e_ev[d] = 0; e_sv[d] = 0; e_b[d] = 0; e_s[d] = 0; e_pe[d] = 0;
        if (m_pend[d]) begin
            e_ev[d]   = 1;
            e_diff[d] = m_pdiff[d];
            if (m_n[d] <= w) m_n[d]++;
            above = m_pdiff[d] > 64'sh800;
            below = m_pdiff[d] < -64'sh800;
            sig = 0;
            if (m_n[d] > w) begin
                if (m_pos[d] == 0) begin
                    if (above) begin m_pos[d] = 1; e_b[d] = 1; sig = 1; end
                    else if (below) begin m_pos[d] = 2; e_s[d] = 1; sig = 1; end
                end else if (m_pos[d] == 1 && below && m_hold[d] == 0) begin
                    m_pos[d] = 2; e_s[d] = 1; sig = 1;
                end else if (m_pos[d] == 2 && above && m_hold[d] == 0) begin
                    m_pos[d] = 1; e_b[d] = 1; sig = 1;
                end
            end
            e_sv[d] = sig;
            if (sig) m_hold[d] = 2;
            else if (m_hold[d] > 0) m_hold[d]--;
        end
        complete = (fv || m_hf[d]) && (sv || m_hs[d]);
        if (complete) begin
            m_pdiff[d] = longint'($signed(fv ? fa : m_vf[d])) - longint'($signed(sv ? sa : m_vs[d]));
            m_pend[d] = 1;
            m_hf[d] = 0;
            m_hs[d] = 0;
        end else begin
            m_pend[d] = 0;
            if (fv) begin e_pe[d] |= m_hf[d]; m_vf[d] = fa; m_hf[d] = 1; end
            if (sv) begin e_pe[d] |= m_hs[d]; m_vs[d] = sa; m_hs[d] = 1; end
        end
    endtask

    task automatic tick();
        bit r, fv, sv;
        logic [31:0] fa, sa;
        r = rst; fv = fast_valid; sv = slow_valid; fa = fast_avg; sa = slow_avg;
        @(posedge clk);
        #1;
        model_step(0, r, fv, fa, sv, sa);
        model_step(1, r, fv, fa, sv, sa);
    endtask

    task automatic chk(input string nm, input logic [32:0] got, input logic [32:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", nm, got, exp, $time);
        end
    endtask

    function automatic logic [32:0] obs(input int d);
        return {26'd0, ev[d], sgv[d], sb[d], ss[d], po[d], pe[d]};
    endfunction

    function automatic logic [32:0] pk(input bit e, input bit v, input bit b, input bit s,
                                       input logic [1:0] p, input bit err);
        return {26'd0, e, v, b, s, p, err};
    endfunction

    task automatic set_in(input bit fv, input logic [31:0] fa, input bit sv, input logic [31:0] sa);
        fast_valid = fv; fast_avg = fa; slow_valid = sv; slow_avg = sa;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        set_in(0, '0, 0, '0);
        tick();
        rst = 1'b0;
    endtask

    // One isolated pair on dut_b, checked two edges after the strobe.
    task automatic pair_chk(input string nm, input logic [31:0] fa, input logic [31:0] sa,
                            input bit v, input bit b, input bit s, input logic [1:0] p);
        longint ed;
        logic [32:0] ex;
        set_in(1, fa, 1, sa);
        tick();
        set_in(0, '0, 0, '0);
        tick();
        ed = longint'($signed(fa)) - longint'($signed(sa));
        ex = ed[32:0];
        chk({nm, "_flags"}, obs(1), pk(1, v, b, s, p, 0));
        chk({nm, "_diff"}, dv[1], ex);
    endtask

    typedef struct {
        bit          fv;
        logic [31:0] fa;
        bit          sv;
        logic [31:0] sa;
        bit          e_ev;
        bit          e_sv;
        bit          e_b;
        bit          e_s;
        logic [1:0]  e_pos;
        logic [32:0] e_diff;
        bit          e_pe;
    } vec_t;

    vec_t tbl [5];

    initial begin
        int evc;
        logic [32:0] ex;
        longint t;

        tbl[0] = '{1, 32'h0002_0000, 1, 32'h0001_0000, 0, 0, 0, 0, 2'b00, 33'h0_0000_0000, 0};
        tbl[1] = '{1, 32'h0002_0000, 1, 32'h0001_0000, 1, 0, 0, 0, 2'b00, 33'h0_0001_0000, 0};
        tbl[2] = '{1, 32'h0002_0000, 1, 32'h0001_0000, 1, 0, 0, 0, 2'b00, 33'h0_0001_0000, 0};
        tbl[3] = '{0, 32'h0,         0, 32'h0,         1, 1, 1, 0, 2'b01, 33'h0_0001_0000, 0};
        tbl[4] = '{0, 32'h0,         0, 32'h0,         0, 0, 0, 0, 2'b01, 33'h0_0001_0000, 0};

        // Reset held while strobing, then quiet release.
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            set_in(1, 32'h0005_0000, 1, 32'h0001_0000);
            tick();
            for (int d = 0; d < 2; d++) begin
                chk($sformatf("rst_hold%0d_dut%0d", i, d), obs(d), pk(0, 0, 0, 0, 2'b00, 0));
                chk($sformatf("rst_diff%0d_dut%0d", i, d), dv[d], 33'd0);
            end
        end
        rst = 1'b0;
        set_in(0, '0, 0, '0);
        for (int i = 0; i < 2; i++) begin
            tick();
            for (int d = 0; d < 2; d++)
                chk($sformatf("rst_quiet%0d_dut%0d", i, d), obs(d), pk(0, 0, 0, 0, 2'b00, 0));
        end

        // Warm-up of two pairs, buy on the third (dut_a).
        for (int i = 0; i < 5; i++) begin
            set_in(tbl[i].fv, tbl[i].fa, tbl[i].sv, tbl[i].sa);
            tick();
            chk($sformatf("warmup_vec%0d_flags", i), obs(0),
                pk(tbl[i].e_ev, tbl[i].e_sv, tbl[i].e_b, tbl[i].e_s, tbl[i].e_pos, tbl[i].e_pe));
            chk($sformatf("warmup_vec%0d_diff", i), dv[0], tbl[i].e_diff);
        end

        // Hysteresis boundaries and hold-off gating (dut_b, no warm-up).
        do_reset();
        pair_chk("hyst_plus_edge", 32'h0000_0800, 32'h0, 0, 0, 0, 2'b00);
        pair_chk("hyst_minus_edge", 32'h0, 32'h0000_0800, 0, 0, 0, 2'b00);
        pair_chk("above_buy", 32'h0000_0801, 32'h0, 1, 1, 0, 2'b01);
        pair_chk("blocked1", 32'h0, 32'h0001_0000, 0, 0, 0, 2'b01);
        pair_chk("blocked2", 32'h0, 32'h0001_0000, 0, 0, 0, 2'b01);
        pair_chk("sell_after_holdoff", 32'h0, 32'h0001_0000, 1, 0, 1, 2'b10);

        // Split arrival: one evaluation, five cycles after the fast strobe.
        do_reset();
        evc = 0;
        for (int k = 0; k < 7; k++) begin
            set_in(k == 0, 32'h0000_5000, k == 3, 32'h0000_5000);
            tick();
            if (ev[1]) evc++;
            chk($sformatf("split_eval_k%0d", k), {32'd0, ev[1]}, {32'd0, k == 4});
        end
        set_in(0, '0, 0, '0);
        chk("split_eval_count", 33'(evc), 33'd1);

        // Overwritten half-pair flags pair_err and the newer value wins.
        set_in(1, 32'h0000_0001, 0, '0);
        tick();
        chk("overwrite_first", {32'd0, pe[1]}, 33'd0);
        set_in(1, 32'h0003_0000, 0, '0);
        tick();
        chk("overwrite_err", {32'd0, pe[1]}, 33'd1);
        set_in(0, '0, 0, '0);
        tick();
        chk("overwrite_err_pulse", {32'd0, pe[1]}, 33'd0);
        set_in(0, '0, 1, 32'h0001_0000);
        tick();
        set_in(0, '0, 0, '0);
        tick();
        chk("overwrite_pair_flags", obs(1), pk(1, 1, 1, 0, 2'b01, 0));
        chk("overwrite_pair_diff", dv[1], 33'h0_0002_0000);

        // Reset while long with a held fast sample discards the half-pair.
        set_in(1, 32'h0004_0000, 0, '0);
        tick();
        rst = 1'b1;
        set_in(0, '0, 0, '0);
        tick();
        chk("midrst_flags", obs(1), pk(0, 0, 0, 0, 2'b00, 0));
        rst = 1'b0;
        set_in(0, '0, 1, 32'h0001_0000);
        tick();
        set_in(0, '0, 0, '0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("midrst_lone_slow%0d", k), obs(1), pk(0, 0, 0, 0, 2'b00, 0));
        end

        // Random traffic against the reference model on both instances.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            logic [31:0] fa, sa;
            rst = ($urandom_range(0, 299) == 0);
            fa = $urandom_range(0, 32'h6000) - 32'h3000;
            sa = $urandom_range(0, 32'h6000) - 32'h3000;
            if ($urandom_range(0, 7) == 0) fa = $urandom;
            if ($urandom_range(0, 7) == 0) sa = $urandom;
            set_in($urandom_range(0, 1), fa, $urandom_range(0, 1), sa);
            tick();
            for (int d = 0; d < 2; d++) begin
                t = e_diff[d];
                ex = t[32:0];
                chk($sformatf("rand_c%0d_dut%0d_flags", c, d), obs(d),
                    pk(e_ev[d], e_sv[d], e_b[d], e_s[d],
                       (m_pos[d] == 1) ? 2'b01 : (m_pos[d] == 2) ? 2'b10 : 2'b00, e_pe[d]));
                chk($sformatf("rand_c%0d_dut%0d_diff", c, d), dv[d], ex);
            end
        end
        rst = 1'b0;
        set_in(0, '0, 0, '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ema_crossover_signal.md
EMA_CROSSOVER_SIGNAL -- requirements
Module: ema_crossover_signal

Interface
REQ-001 SHALL have parameter HYST, default 32'h0000_0800, hysteresis band in Q16.16, treated as unsigned non-negative.
REQ-002 SHALL have parameter HOLDOFF, default 4, count of evaluated pairs during which position reversals are blocked after any signal.
REQ-003 SHALL have parameter WARMUP, default 16, count of evaluated pairs consumed before any signal may be issued; 0 means no warm-up.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 fast_valid  input  1  fast-EMA sample strobe.
REQ-007 fast_avg  input  32  fast EMA, signed Q16.16.
REQ-008 slow_valid  input  1  slow-EMA sample strobe.
REQ-009 slow_avg  input  32  slow EMA, signed Q16.16.
REQ-010 eval_valid  output  1  one-cycle pulse per evaluated pair.
REQ-011 diff_out  output  33  last evaluated fast minus slow, signed Q17.16.
REQ-012 sig_valid  output  1  one-cycle pulse when a trade signal is issued.
REQ-013 sig_buy / sig_sell  output  1 each  direction of issued signal; valid only with sig_valid, mutually exclusive.
REQ-014 position  output  2  00 flat, 01 long, 10 short; 11 never driven.
REQ-015 pair_err  output  1  one-cycle pulse when a held half-pair is overwritten.

Function
REQ-016 Pairing: fast/slow samples held in separate registers with flags have_fast/have_slow; a pair completes on the edge where both are available (held or arriving that cycle, same-cycle arrival included).
REQ-017 On pair completion both flags SHALL clear; a value arriving with its strobe is used directly, not the stale held copy.
REQ-018 A strobe arriving while its own flag is set and the pair incomplete SHALL overwrite the held value and pulse pair_err the following cycle.
REQ-019 Stage 1 (pair-completion edge E): diff = sext33(fast) - sext33(slow), 33-bit exact, no overflow; registered.
REQ-020 Stage 2 (edge E+1): region ABOVE if diff > +HYST, BELOW if diff < -HYST, else INSIDE (boundaries inclusive to INSIDE); FSM, position, diff_out, eval_valid, sig_* update on this edge.
REQ-021 Latency: strobe sampled at edge E, eval_valid/sig_valid high for exactly the cycle after edge E+1; back-to-back pairs every cycle SHALL be supported.
REQ-022 FSM states WARMUP, NEUTRAL, LONG, SHORT; position 00 in WARMUP/NEUTRAL, 01 LONG, 10 SHORT.
REQ-023 WARMUP: pairs 1..WARMUP counted, no signals; leave to NEUTRAL on pair WARMUP; first decision on pair WARMUP+1.
REQ-024 NEUTRAL: ABOVE -> LONG with buy; BELOW -> SHORT with sell; INSIDE -> stay.
REQ-025 LONG: BELOW and holdoff counter 0 -> SHORT with sell; otherwise stay. SHORT symmetric with ABOVE/buy.
REQ-026 Holdoff counter loaded with HOLDOFF on every issued signal; decremented once per evaluated pair not issuing a signal, saturating at 0; gating decision uses value before decrement.
REQ-027 Blocked crossings SHALL be dropped, not deferred; next pair re-evaluates.
REQ-028 Only pair completions advance counters; idle cycles change nothing.

Reset
REQ-029 While rst high: all outputs 0, position 00, FSM WARMUP, warm-up and holdoff counters 0, pairing flags and pipeline cleared; rst overrides concurrent strobes.
REQ-030 Reset mid-operation SHALL discard held half-pairs and any in-flight stage-1 result; no pulse after rst deasserts until a new pair completes.

Verification
REQ-031 Reset: rst 2 cycles while strobing -> all outputs 0, position 00, no pulses for 2 cycles after release without strobes.
REQ-032 WARMUP=2,HOLDOFF=2: 3 same-cycle pairs fast=0x00020000 slow=0x00010000 -> eval_valid x3, diff_out 0x0_00010000, sig_buy only on 3rd pair, 2 cycles after its strobe, position 01.
REQ-033 WARMUP=0: pair with diff exactly +0x800 then -0x800 -> no signals, position 00; then diff +0x801 -> buy.
REQ-034 WARMUP=0,HOLDOFF=2 after buy: 3 pairs diff=-0x10000 -> pairs 1,2 blocked, sell on pair 3, position 10.
REQ-035 Split arrival: fast at t, slow at t+3 -> single eval_valid at t+5; two fast strobes (0x1,0x30000) before slow -> pair_err pulse, diff uses 0x30000.
REQ-036 In LONG with fast held, assert rst -> position 00; subsequent lone slow strobe produces no eval_valid.
